// File: rtl/axis_pkt_mux.sv
// axis_pkt_mux: packet-locked NUM_CH:1 AXI-Stream multiplexer.
// The channel grant is held for a whole packet and only re-arbitrated after an accepted tlast.
// Output is fully registered: a main register drives m_*, and a one-deep skid register
// absorbs the beat that is already in flight when m_tready drops, so s_tready never
// depends combinationally on m_tready.
// Optional feature: define AXIS_PKT_MUX_RR_EN to enable round-robin arbitration via auto_en.
module axis_pkt_mux #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     auto_en,
    input  logic [NUM_CH*DATA_W-1:0] s_tdata,
    input  logic [NUM_CH-1:0]        s_tvalid,
    input  logic [NUM_CH-1:0]        s_tlast,
    output logic [NUM_CH-1:0]        s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic                     busy,
    output logic [SEL_W-1:0]         cur_ch
);

    localparam logic [SEL_W-1:0] LastGrantRst = SEL_W'(NUM_CH - 1);

    typedef enum logic [0:0] {
        st_idle,
        st_lock
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic              m_tvalid_q, m_tvalid_d;
    logic              m_tlast_q, m_tlast_d;
    logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
    logic              skid_full_q, skid_full_d;
    logic              skid_last_q, skid_last_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [DATA_W-1:0] beat_data;
    logic              beat_last;
    logic              accept;
    logic              main_free;
    logic [SEL_W-1:0]  cand;
    logic              cand_ok;

    // Unpack the flat tdata bus into per-channel words.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            ch_data[i] = s_tdata[i*DATA_W +: DATA_W];
        end
    end

    assign beat_data = ch_data[cur_ch_q];
    assign beat_last = s_tlast[cur_ch_q];
    // Skid-full gates acceptance: with both registers occupied there is nowhere to put a beat.
    assign accept    = (state_q == st_lock) && s_tvalid[cur_ch_q] && !skid_full_q;
    assign main_free = !m_tvalid_q || m_tready;

`ifdef AXIS_PKT_MUX_RR_EN
    logic [SEL_W-1:0] rr_cand;
    logic             rr_hit;

    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % int'(NUM_CH);
        return SEL_W'(sum);
    endfunction

    // Round-robin search from last_grant+1; walking down lets the nearest hit win.
    always_comb begin
        rr_cand = '0;
        rr_hit  = 1'b0;
        for (int off = int'(NUM_CH); off >= 1; off--) begin
            if (s_tvalid[wrap_add(last_grant_q, off)]) begin
                rr_hit  = 1'b1;
                rr_cand = wrap_add(last_grant_q, off);
            end
        end
    end
`else
    logic unused_auto_en;
    assign unused_auto_en = auto_en;
`endif

    // Pick the IDLE-state candidate; an out-of-range sel is never granted.
    always_comb begin
        cand    = sel;
        cand_ok = (32'(sel) < NUM_CH) && s_tvalid[sel];
`ifdef AXIS_PKT_MUX_RR_EN
        if (auto_en) begin
            cand    = rr_cand;
            cand_ok = rr_hit;
        end
`endif
    end

    // FSM next state: grant in IDLE, release on an accepted tlast.
    always_comb begin
        state_d      = state_q;
        cur_ch_d     = cur_ch_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            st_idle: begin
                if (cand_ok) begin
                    state_d      = st_lock;
                    cur_ch_d     = cand;
                    last_grant_d = cand;
                end
            end
            st_lock: begin
                if (accept && beat_last) begin
                    state_d = st_idle;
                end
            end
            default: state_d = st_idle;
        endcase
    end

    // Output stage next state: main register refills from skid first to keep beat order.
    always_comb begin
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        m_tdata_d   = m_tdata_q;
        skid_full_d = skid_full_q;
        skid_last_d = skid_last_q;
        skid_data_d = skid_data_q;
        if (main_free) begin
            if (skid_full_q) begin
                // accept is impossible here since skid_full blocks s_tready
                m_tvalid_d  = 1'b1;
                m_tlast_d   = skid_last_q;
                m_tdata_d   = skid_data_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                m_tvalid_d = 1'b1;
                m_tlast_d  = beat_last;
                m_tdata_d  = beat_data;
            end else begin
                m_tvalid_d = 1'b0;
            end
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_last_d = beat_last;
            skid_data_d = beat_data;
        end
    end

    // State and datapath registers; reset discards any in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= st_idle;
            cur_ch_q     <= '0;
            last_grant_q <= LastGrantRst;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tdata_q    <= '0;
            skid_full_q  <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_ch_q     <= cur_ch_d;
            last_grant_q <= last_grant_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            m_tdata_q    <= m_tdata_d;
            skid_full_q  <= skid_full_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // Only the locked channel may see ready, and only while the skid slot is free.
    always_comb begin
        s_tready = '0;
        if (state_q == st_lock) begin
            s_tready[cur_ch_q] = !skid_full_q;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tdata  = m_tdata_q;
    assign busy     = (state_q == st_lock);
    assign cur_ch   = cur_ch_q;

endmodule

// File: tb/tb_axis_pkt_mux.sv
// Testbench for axis_pkt_mux: table-driven packet vectors plus hand-written corner sequences.
// Accepted beats go into a scoreboard queue and are matched against the output stream.
module tb_axis_pkt_mux;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int ch;
        int len;
        int base;
        int rdy;
        int exp_ch;
        int exp_beats;
        int exp_busy;
    } vec_t;

    logic                     clk;
    logic                     rst_n;
    logic [SEL_W-1:0]         sel;
    logic                     auto_en;
    logic [NUM_CH*DATA_W-1:0] s_tdata;
    logic [NUM_CH-1:0]        s_tvalid;
    logic [NUM_CH-1:0]        s_tlast;
    logic [NUM_CH-1:0]        s_tready;
    logic [DATA_W-1:0]        m_tdata;
    logic                     m_tvalid;
    logic                     m_tlast;
    logic                     m_tready;
    logic                     busy;
    logic [SEL_W-1:0]         cur_ch;

    axis_pkt_mux #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .auto_en  (auto_en),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .busy     (busy),
        .cur_ch   (cur_ch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    beat_t src_q [NUM_CH][$];
    beat_t exp_q [$];
    int    grant_log [$];
    int    acc_cyc [$];
    int    acc_ch [$];
    int    out_cyc [$];
    int    occ, out_cnt, acc_cnt, busy_cycles, last_cnt;
    int    rdy_mode, rdy_idx;
    logic  prev_busy, prev_hold, prev_last;
    logic [7:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic all_empty();
        logic e = 1'b1;
        for (int i = 0; i < int'(NUM_CH); i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i]                  = 1'b1;
                s_tdata[i*DATA_W +: DATA_W]  = src_q[i][0].data;
                s_tlast[i]                   = src_q[i][0].last;
            end else begin
                s_tvalid[i]                  = 1'b0;
                s_tdata[i*DATA_W +: DATA_W]  = 8'h00;
                s_tlast[i]                   = 1'b0;
            end
        end
        case (rdy_mode)
            1:       m_tready = (rdy_idx % 3 == 0);
            2:       m_tready = (rdy_idx % 2 == 0);
            default: m_tready = 1'b1;
        endcase
        rdy_idx++;
    endtask

    task automatic clear_stats();
        grant_log.delete();
        acc_cyc.delete();
        acc_ch.delete();
        out_cyc.delete();
        out_cnt     = 0;
        acc_cnt     = 0;
        busy_cycles = 0;
        last_cnt    = 0;
    endtask

    task automatic flush_model();
        for (int i = 0; i < int'(NUM_CH); i++) src_q[i].delete();
        exp_q.delete();
        occ       = 0;
        prev_busy = 1'b0;
        prev_hold = 1'b0;
    endtask

    task automatic load_pkt(input int ch, input int len, input int base);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = 8'(base + j);
            b.last = (j == len - 1);
            src_q[ch].push_back(b);
        end
    endtask

    // One clock: check and sample at negedge, then apply handshakes and redrive at posedge+1.
    task automatic cycle();
        logic [NUM_CH-1:0] acc;
        logic              fire;
        logic [7:0]        od;
        logic              ol;
        beat_t             b;
        @(negedge clk);
        if (busy && occ < 2) check("s_tready_lock", 32'(s_tready), 32'(1) << cur_ch);
        else check("s_tready_blocked", 32'(s_tready), 32'd0);
        if (prev_hold) begin
            check("m_hold_valid", 32'(m_tvalid), 32'd1);
            check("m_hold_data", {23'd0, m_tlast, m_tdata}, {23'd0, prev_last, prev_data});
        end
        prev_hold = m_tvalid && !m_tready;
        prev_data = m_tdata;
        prev_last = m_tlast;
        if (busy) busy_cycles++;
        acc  = s_tvalid & s_tready;
        fire = m_tvalid & m_tready;
        od   = m_tdata;
        ol   = m_tlast;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (acc[i] && src_q[i].size() > 0) begin
                b = src_q[i].pop_front();
                exp_q.push_back(b);
                occ++;
                acc_cnt++;
                acc_cyc.push_back(cyc);
                acc_ch.push_back(i);
            end
        end
        if (fire) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", 32'(od), 32'hFFFF_FFFF);
            end else begin
                b = exp_q.pop_front();
                check("out_data", 32'(od), 32'(b.data));
                check("out_last", 32'(ol), 32'(b.last));
                occ--;
            end
            out_cnt++;
            out_cyc.push_back(cyc);
            if (ol) last_cnt++;
        end
        if (busy && !prev_busy) grant_log.push_back(int'(cur_ch));
        prev_busy = busy;
        drive_inputs();
    endtask

    task automatic run_until_drained(input int max_cyc, input string name);
        int n = 0;
        while (!(all_empty() && exp_q.size() == 0 && !busy) && n < max_cyc) begin
            cycle();
            n++;
        end
        check({name, "_timeout"}, 32'(n < max_cyc), 32'd1);
    endtask

    task automatic check_grants(input string name, input int exp [$]);
        check({name, "_grant_cnt"}, 32'(grant_log.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < grant_log.size(); k++) begin
            check({name, "_grant"}, 32'(grant_log[k]), 32'(exp[k]));
        end
    endtask

    initial begin
        vec_t vecs [6];
        int   n;
        int   exp_g [$];

        vecs[0] = '{ch: 2, len: 4,  base: 'hA0, rdy: 0, exp_ch: 2, exp_beats: 4,  exp_busy: 4};
        vecs[1] = '{ch: 0, len: 3,  base: 'h10, rdy: 0, exp_ch: 0, exp_beats: 3,  exp_busy: 3};
        vecs[2] = '{ch: 3, len: 1,  base: 'h55, rdy: 0, exp_ch: 3, exp_beats: 1,  exp_busy: 1};
        vecs[3] = '{ch: 1, len: 16, base: 'h00, rdy: 1, exp_ch: 1, exp_beats: 16, exp_busy: -1};
        vecs[4] = '{ch: 2, len: 2,  base: 'hF0, rdy: 1, exp_ch: 2, exp_beats: 2,  exp_busy: -1};
        vecs[5] = '{ch: 1, len: 6,  base: 'h30, rdy: 2, exp_ch: 1, exp_beats: 6,  exp_busy: -1};

        rst_n    = 1'b0;
        sel      = '0;
        auto_en  = 1'b0;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        rdy_mode = 0;
        rdy_idx  = 0;
        flush_model();
        clear_stats();

        repeat (3) @(posedge clk);
        #2;
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_m_tdata", 32'(m_tdata), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_ch", 32'(cur_ch), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single-packet vectors in fixed-select mode.
        for (int v = 0; v < 6; v++) begin
            clear_stats();
            sel      = SEL_W'(vecs[v].ch);
            auto_en  = 1'b0;
            rdy_mode = vecs[v].rdy;
            rdy_idx  = 0;
            load_pkt(vecs[v].ch, vecs[v].len, vecs[v].base);
            drive_inputs();
            run_until_drained(400, "vec");
            check("vec_beats", 32'(out_cnt), 32'(vecs[v].exp_beats));
            check("vec_lasts", 32'(last_cnt), 32'd1);
            exp_g = '{vecs[v].exp_ch};
            check_grants("vec", exp_g);
            if (vecs[v].exp_busy >= 0) begin
                check("vec_busy_cycles", 32'(busy_cycles), 32'(vecs[v].exp_busy));
                check("vec_latency", 32'(out_cyc[0] - acc_cyc[0]), 32'd1);
                check("vec_back_to_back", 32'(out_cyc[out_cyc.size()-1] - out_cyc[0]),
                      32'(vecs[v].len - 1));
            end
        end

        // Select change mid-packet: ch1 keeps the lock, ch0 waits for the IDLE cycle.
        clear_stats();
        rdy_mode = 0;
        sel      = 2'd1;
        load_pkt(1, 5, 'h10);
        load_pkt(0, 2, 'h20);
        drive_inputs();
        n = 0;
        while (acc_cnt < 2 && n < 50) begin
            cycle();
            n++;
        end
        check("selchg_reach_beat2", 32'(acc_cnt >= 2), 32'd1);
        sel = 2'd0;
        run_until_drained(100, "selchg");
        check("selchg_beats", 32'(out_cnt), 32'd7);
        exp_g = '{1, 0};
        check_grants("selchg", exp_g);
        if (acc_ch.size() == 7) begin
            check("selchg_last_ch1", 32'(acc_ch[4]), 32'd1);
            check("selchg_first_ch0", 32'(acc_ch[5]), 32'd0);
            check("selchg_gap", 32'(acc_cyc[5] - acc_cyc[4]), 32'd2);
        end else begin
            check("selchg_acc_cnt", 32'(acc_ch.size()), 32'd7);
        end

        // Single-beat packets, alternating sel: one output every two cycles.
        clear_stats();
        sel = 2'd0;
        for (int j = 0; j < 3; j++) begin
            load_pkt(0, 1, 'h40 + j);
            load_pkt(1, 1, 'h50 + j);
        end
        drive_inputs();
        n = 0;
        while (!(all_empty() && exp_q.size() == 0 && !busy) && n < 100) begin
            cycle();
            sel = SEL_W'(acc_cnt % 2);
            n++;
        end
        check("single_timeout", 32'(n < 100), 32'd1);
        check("single_beats", 32'(out_cnt), 32'd6);
        check("single_lasts", 32'(last_cnt), 32'd6);
        exp_g = '{0, 1, 0, 1, 0, 1};
        check_grants("single", exp_g);
        for (int k = 1; k < out_cyc.size(); k++) begin
            check("single_spacing", 32'(out_cyc[k] - out_cyc[k-1]), 32'd2);
        end

        // Asynchronous reset during beat 3 of a ch0 packet.
        clear_stats();
        sel = 2'd0;
        load_pkt(0, 6, 'h60);
        drive_inputs();
        n = 0;
        while (acc_cnt < 3 && n < 50) begin
            cycle();
            n++;
        end
        check("arst_reach_beat3", 32'(acc_cnt >= 3), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("arst_m_tlast", 32'(m_tlast), 32'd0);
        check("arst_m_tdata", 32'(m_tdata), 32'd0);
        check("arst_s_tready", 32'(s_tready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cur_ch", 32'(cur_ch), 32'd0);
        flush_model();
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_stats();
`ifdef AXIS_PKT_MUX_RR_EN
        auto_en = 1'b1;
        sel     = 2'd3;
        load_pkt(0, 2, 'h70);
        load_pkt(3, 2, 'h80);
        drive_inputs();
        run_until_drained(100, "arst_after");
        exp_g = '{0, 3};
        check_grants("arst_after", exp_g);

        // Round-robin over ch0, ch1, ch3 sending 2-beat packets back to back.
        clear_stats();
        for (int j = 0; j < 3; j++) begin
            load_pkt(0, 2, 'h00 + 2 * j);
            load_pkt(1, 2, 'h10 + 2 * j);
            load_pkt(3, 2, 'h30 + 2 * j);
        end
        drive_inputs();
        run_until_drained(200, "rr");
        check("rr_beats", 32'(out_cnt), 32'd18);
        exp_g = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
        check_grants("rr", exp_g);
        for (int k = 1; k < acc_cyc.size(); k++) begin
            check("rr_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), (k % 2 == 0) ? 32'd2 : 32'd1);
        end
        auto_en = 1'b0;
`else
        sel = 2'd0;
        load_pkt(0, 2, 'h70);
        drive_inputs();
        run_until_drained(100, "arst_after");
        exp_g = '{0};
        check_grants("arst_after", exp_g);

        // Without round-robin support auto_en has no effect: sel alone decides.
        clear_stats();
        auto_en = 1'b1;
        sel     = 2'd2;
        load_pkt(0, 1, 'hC0);
        load_pkt(2, 1, 'hC2);
        drive_inputs();
        n = 0;
        while (out_cnt < 1 && n < 50) begin
            cycle();
            n++;
        end
        sel = 2'd0;
        run_until_drained(100, "noauto");
        exp_g = '{2, 0};
        check_grants("noauto", exp_g);
        auto_en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_pkt_mux.md
# axis_pkt_mux

Packet-aware N:1 AXI-Stream multiplexer with registered output, the parametrised successor to the two-way combinational stream selector in the AES/UART datapath. It merges NUM_CH upstream streams (cipher, bypass, status, etc.) onto one downstream stream. The channel choice is locked for the length of each packet, so channel changes happen only on `tlast` boundaries. A two-entry skid buffer breaks the `tready` combinational path while sustaining one beat per cycle.

## Interface
Parameters:
- NUM_CH, 4: number of input channels; must be at least 2.
- DATA_W, 8: tdata width in bits.
- SEL_W, $clog2(NUM_CH): width of `sel` and `cur_ch`. Derived; not overridden.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- sel  in  SEL_W  requested channel in fixed-select mode.
- auto_en  in  1  1 = round-robin arbitration (see Configuration).
- s_tdata  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- s_tvalid  in  NUM_CH  per-channel valid.
- s_tlast  in  NUM_CH  per-channel last.
- s_tready  out  NUM_CH  per-channel ready.
- m_tdata  out  DATA_W  output data, registered.
- m_tvalid  out  1  output valid, registered.
- m_tlast  out  1  output last, registered.
- m_tready  in  1  downstream ready.
- busy  out  1  high while a packet is locked.
- cur_ch  out  SEL_W  locked or last-granted channel.

## Operation
- FSM with two states: IDLE and LOCK. Reset state is IDLE.
- **IDLE, grant selection:**
  - Fixed-select mode: the candidate is `sel`.
  - Round-robin mode: the candidate is the first channel with `s_tvalid` set, searching from `last_grant+1` and wrapping modulo NUM_CH.
  - The grant fires when the candidate's `s_tvalid` is 1.
  - On the grant edge: `cur_ch` <= candidate, `last_grant` <= candidate, state -> LOCK.
  - No beat is accepted in IDLE. All `s_tready` are 0.
- **LOCK:**
  - `s_tready[cur_ch]` = NOT skid_full. All other `s_tready` bits are 0.
  - A beat is accepted when `s_tvalid[cur_ch]` and `s_tready[cur_ch]` are both high.
  - An accepted beat with `s_tlast`=1 returns the state to IDLE on the same edge.
  - Changes to `sel` or `auto_en` while in LOCK are ignored until the next IDLE.
- **Output stage:**
  - Main register drives `m_*`. One skid register sits behind it.
  - An accepted beat goes to the main register if it is empty or draining this cycle; otherwise it goes to the skid register.
  - When the main register drains and the skid register is full, the skid contents move to the main register.
  - skid_full is a registered flag.
  - Beat order is preserved. No beat is dropped or duplicated.
- `busy` = (state == LOCK).
- Packet length is unbounded. A one-beat packet (tlast on the first beat) is legal.
- `cur_ch` values of NUM_CH or above are impossible. An out-of-range `sel` in IDLE (possible when NUM_CH is not a power of 2) is never granted, and the FSM stays in IDLE.

## Timing
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `s_tready`=0, `busy`=0, `cur_ch`=0, skid empty, `last_grant`=NUM_CH-1 (so channel 0 has first round-robin priority).
- Reset mid-packet: the in-flight beats in the main and skid registers are discarded. The upstream must restart the packet.
- Grant latency: `s_tvalid` high in IDLE at edge k gives LOCK after k, with `s_tready` high during cycle k+1.
- Data latency: a beat accepted at edge n appears on `m_tvalid` after edge n, provided the main register is free.
- Throughput: 1 beat per cycle in LOCK with `m_tready`=1.
- Packet gap: exactly one IDLE cycle between consecutive packets, including packets from the same channel.
- Output stability: `m_tdata` and `m_tlast` hold while `m_tvalid`=1 and `m_tready`=0.
- Backpressure: `s_tready` deasserts no later than the cycle after the skid register fills.

## Configuration
- AXIS_PKT_MUX_RR_EN
  - Defined: `auto_en`=1 selects round-robin arbitration as described above.
  - Undefined: `auto_en` is ignored and the round-robin logic is not synthesised. Every grant uses `sel`, and `last_grant` is still tracked for `cur_ch`.

## Test plan
- Fixed select, reset:
  - Stimulus: `sel`=2, `auto_en`=0, ch2 sends 4 beats 0xA0..0xA3 with tlast on 0xA3, `m_tready`=1.
  - Required: `m_*` shows 0xA0..0xA3 on consecutive cycles, `m_tlast` only on 0xA3, `busy` drops after tlast. `s_tready[0,1,3]`=0 throughout.
- Select change mid-packet:
  - Stimulus: lock ch1, switch `sel` to 0 after beat 2 of 5.
  - Required: all 5 ch1 beats are delivered. Ch0 is granted only after the IDLE cycle.
- Backpressure:
  - Stimulus: `m_tready` toggled 1,0,0,1,... over a 16-beat packet of values 0..15.
  - Required: output sequence 0..15 exactly, with no loss or duplication. `s_tready` is low while the skid register is full.
- Round-robin (with AXIS_PKT_MUX_RR_EN):
  - Stimulus: `auto_en`=1, ch0, ch1 and ch3 continuously send 2-beat packets.
  - Required: grant order 0,1,3,0,1,3,... with one gap cycle between packets.
- Async reset mid-packet:
  - Stimulus: assert `rst_n`=0 during beat 3 of ch0.
  - Required: outputs go to reset values immediately. After release, the next grant goes to ch0 under round-robin.
- Single-beat packets:
  - Stimulus: alternating `sel` 0/1, each packet being a 1-beat tlast.
  - Required: one output beat every 2 cycles, each with `m_tlast`=1.
